// File: rtl/wb_line_memory_pkg.sv
// Shared LC-3b word/line types for the memory-side bus.
// Imported by the line memory and its storage array.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
endpackage

// File: rtl/wb_line_memory_array.sv
// Line storage: synchronous write, asynchronous read.
// Contents are not reset.
module memory_line_array
  import lc3b_types::*;
#(
  parameter int LINES = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  lc3b_line      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output lc3b_line      rdata_o
);

  lc3b_line mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_line_memory.sv
// Wishbone-style 128-bit line memory with fixed latency,
// periodic refresh busy windows and ack/retry completion.
module wb_line_memory
  import lc3b_types::*;
#(
  parameter int LATENCY        = 4,
  parameter int ADDR_LINES     = 64,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_LEN    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     mem_cyc,
  input  logic     mem_stb,
  input  logic     mem_we,
  input  lc3b_word mem_address,
  input  lc3b_line mem_wdata,
  output lc3b_line mem_rdata,
  output logic     mem_ack,
  output logic     mem_rty
);

  localparam int IW = (ADDR_LINES > 1) ? $clog2(ADDR_LINES) : 1;
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam int CW = 8;

  typedef enum logic [1:0] {
    mem_idle,
    mem_wait,
    mem_ack_s,
    mem_release
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [RW-1:0]  ref_q;
  logic [IW-1:0]  idx_q;
  logic           we_q;
  lc3b_line       wdata_q;
  lc3b_line       rdata_q;

  logic           req;
  logic           busy;
  logic           ref_wrap;
  logic [IW-1:0]  addr_idx;
  logic [IW-1:0]  rd_idx;
  logic           wr_en;
  lc3b_line       rd_line;
  logic           unused_addr;

  assign req         = mem_cyc & mem_stb;
  assign addr_idx    = mem_address[4 +: IW];
  assign unused_addr = ^mem_address;
  assign ref_wrap    = (int'(ref_q) == REFRESH_PERIOD - 1);
  assign busy        = (int'(ref_q) < REFRESH_LEN);

  // Address straight from the bus while idle, latched index afterwards.
  assign rd_idx = (state_q == mem_idle) ? addr_idx : idx_q;
  assign wr_en  = (state_q == mem_ack_s) & req & we_q;

  assign mem_ack   = (state_q == mem_ack_s) & req;
  assign mem_rty   = (state_q == mem_idle) & req & busy;
  assign mem_rdata = rdata_q;

  memory_line_array #(
    .LINES (ADDR_LINES),
    .AW    (IW)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (rd_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= mem_idle;
      cnt_q   <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ref_q <= ref_wrap ? '0 : ref_q + 1'b1;
      unique case (state_q)
        mem_idle: begin
          if (req && !busy) begin
            idx_q   <= addr_idx;
            we_q    <= mem_we;
            wdata_q <= mem_wdata;
            cnt_q   <= CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= mem_ack_s;
              if (!mem_we) begin
                rdata_q <= rd_line;
              end
            end else begin
              state_q <= mem_wait;
            end
          end
        end
        mem_wait: begin
          if (!req) begin
            state_q <= mem_idle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // Entering ACK on the edge where the count hits zero.
            if (cnt_q <= CW'(1)) begin
              state_q <= mem_ack_s;
              if (!we_q) begin
                rdata_q <= rd_line;
              end
            end
          end
        end
        mem_ack_s: begin
          state_q <= req ? mem_release : mem_idle;
        end
        mem_release: begin
          if (!req) begin
            state_q <= mem_idle;
          end
        end
        default: state_q <= mem_idle;
      endcase
    end
  end

endmodule

// File: doc/wb_line_memory.md
# wb_line_memory

Physical-memory responder on the cache's memory-side Wishbone-style interface. It accepts 128-bit line read and write cycles from the cache controller, models a fixed access latency and periodic refresh busy windows, and completes each cycle with a single-cycle `mem_ack` or rejects it with `mem_rty`. It sits between the cache controller's `mem_*` port and the backing line storage, and serves as the synthesizable/simulation stand-in for main memory.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `mem_ack`; legal range 1..255.
- `ADDR_LINES`, default 64: number of 128-bit lines stored; power of two.
- `REFRESH_PERIOD`, default 64: refresh counter modulus; must be at least 2.
- `REFRESH_LEN`, default 2: busy cycles at the start of each period; 0 disables refresh; must be less than `REFRESH_PERIOD`.
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_cyc` in 1: cycle valid from the initiator.
- `mem_stb` in 1: strobe from the initiator.
- `mem_we` in 1: 1 means line write, 0 means line read.
- `mem_address` in 16 (`lc3b_word`): byte address; bits [15:4] select the line and bits [3:0] are ignored.
- `mem_wdata` in 128 (`lc3b_line`): write line.
- `mem_rdata` out 128 (`lc3b_line`): read line, registered.
- `mem_ack` out 1: single-cycle completion.
- `mem_rty` out 1: request refused; the initiator must retry.

## Operation
- A request is present when `mem_cyc & mem_stb`.
- The line index is `mem_address[4 +: log2(ADDR_LINES)]`. Higher address bits alias.
- FSM states:
  - **IDLE**
    - If a request is present and `busy` is 0: latch the index, `mem_we` and `mem_wdata`; load the wait counter with `LATENCY-1`. Go to WAIT, or directly to ACK when `LATENCY==1`.
    - If a request is present and `busy` is 1: `mem_rty`=1 combinationally; stay in IDLE.
  - **WAIT**
    - Decrement the counter each cycle. When the counter reaches 0, go to ACK.
    - If the request drops (`!(mem_cyc & mem_stb)`), abort: go to IDLE with no array write.
  - **ACK**
    - `mem_ack = mem_cyc & mem_stb`.
    - For a write, commit the latched data to the array at the end of this cycle, only if the request is still present.
    - Go to RELEASE. If the request has dropped, go to IDLE and commit nothing.
  - **RELEASE**: wait until the request drops, then go to IDLE. No new request is accepted until this happens.
- Reads: `mem_rdata` is loaded from the array on the transition into ACK and holds until the next read load. Writes do not change `mem_rdata`.
- Refresh: a free-running counter counts modulo `REFRESH_PERIOD`. `busy = (refcnt < REFRESH_LEN)`. `busy` affects acceptance in IDLE only; in-flight cycles are never retried.
- Changes to address, `we` or data after acceptance are ignored.

## Timing
- Reset values (asynchronous): state IDLE, wait counter 0, `refcnt` 0, `mem_rdata` 0. `mem_ack` and `mem_rty` are 0 as a consequence of IDLE with no request.
- The array contents are not reset.
- Acceptance happens at edge E0. `mem_ack` is high in the cycle after edge E0+`LATENCY`-1, so there are exactly `LATENCY` cycles of latency.
- `mem_ack` and `mem_rty` are never high together, and each is high for at most one cycle per request.
- Reset asserted mid-cycle: the FSM returns to IDLE immediately, any pending write is discarded, and `mem_ack` drops asynchronously.
- Back-to-back requests: the initiator drops `stb` for at least one cycle (RELEASE→IDLE), so the minimum request-to-request spacing is `LATENCY`+2 cycles.
- A request arriving on the first non-busy cycle after a refresh window is accepted that cycle.

## Structure
- `lc3b_types` provides `lc3b_word` and `lc3b_line`.
- `lc3b_types` gains `lc3b_line` (`logic [127:0]`) if it is missing.
- The FSM state enum (`mem_idle`, `mem_wait`, `mem_ack_s`, `mem_release`) is local to the module.
- One sub-module, `memory_line_array`: `ADDR_LINES` x 128 storage with synchronous write and asynchronous read, no reset. The FSM and counters stay in `wb_line_memory`.

## Test plan
- Write then read with `LATENCY`=4 and `REFRESH_LEN`=0:
  - write line 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 at address 0x0040 → `mem_ack` in the 4th cycle after acceptance;
  - read 0x004A (same line) → the same 128-bit value, with `ack` exactly 4 cycles after acceptance.
- Refresh retry with `REFRESH_PERIOD`=8 and `REFRESH_LEN`=2:
  - request at `refcnt`=0 → `mem_rty`=1 and no acceptance;
  - initiator drops `stb` and reasserts at `refcnt`=2 → accepted, `ack` after `LATENCY`.
- Abort: assert a write to 0x0010, drop `cyc`/`stb` during WAIT → no `ack`, and a subsequent read of 0x0010 returns the previous contents.
- Cache sequence: write_back then allocate (`ack`, one idle cycle, new read) → the second request is accepted the cycle `stb` returns, each `ack` lasts one cycle, and there is no `rty` when `REFRESH_LEN`=0.
- `LATENCY`=1: `ack` comes the cycle after acceptance; hold `stb` high after `ack` → no second `ack` until `stb` drops.
- Reset mid-WAIT on a write to 0x0020 → `mem_ack` stays 0 and the line contents are unchanged.
